// File: rtl/sc_pkg.sv
// Shared definitions for stochastic-computing generators: FSM encoding and
// the maximal-length LFSR tap masks indexed by register width.
`timescale 1ns/1ps
package sc_pkg;

    // Generator stream state: IDLE waits for a load, RUN emits stream bits.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sc_state_t;

    localparam int LFSR_MIN_WIDTH = 4;
    localparam int LFSR_MAX_WIDTH = 16;

    // Tap mask for a Fibonacci LFSR shifting toward the MSB. Tap n (1-based)
    // maps to mask bit n-1; the feedback is the XOR of the masked state bits.
    // Every mask gives a maximal period of 2^width - 1 over the nonzero states.
    function automatic logic [LFSR_MAX_WIDTH-1:0] lfsr_taps(input int width);
        logic [LFSR_MAX_WIDTH-1:0] mask;
        case (width)
            4:       mask = 16'h000C; // {4,3}
            5:       mask = 16'h0014; // {5,3}
            6:       mask = 16'h0030; // {6,5}
            7:       mask = 16'h0060; // {7,6}
            8:       mask = 16'h00B8; // {8,6,5,4}
            9:       mask = 16'h0110; // {9,5}
            10:      mask = 16'h0240; // {10,7}
            11:      mask = 16'h0500; // {11,9}
            12:      mask = 16'h0E08; // {12,11,10,4}
            13:      mask = 16'h1C80; // {13,12,11,8}
            14:      mask = 16'h3802; // {14,13,12,2}
            15:      mask = 16'h6000; // {15,14}
            16:      mask = 16'hD008; // {16,15,13,4}
            default: mask = 16'h0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/sc_lfsr.sv
// Maximal-length Fibonacci LFSR: shifts toward the MSB, new LSB is the XOR
// of the tap bits. init reloads SEED and takes priority over step.
`timescale 1ns/1ps
module sc_lfsr
    import sc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SEED  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init,
    input  logic             step,
    output logic [WIDTH-1:0] state
);

    localparam logic [LFSR_MAX_WIDTH-1:0] TAPS_FULL = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0]          TAPS      = TAPS_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0]          SEED_V    = WIDTH'(SEED);

    logic [WIDTH-1:0] state_reg;
    logic [WIDTH-1:0] tap_bits;
    logic             feedback;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_tap
            assign tap_bits[gi] = state_reg[gi] & TAPS[gi];
        end
    endgenerate

    assign feedback = ^tap_bits;

    // Shift register: reload seed on init, otherwise advance on step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= SEED_V;
        end else if (init) begin
            state_reg <= SEED_V;
        end else if (step) begin
            state_reg <= {state_reg[WIDTH-2:0], feedback};
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/sc_sng.sv
// Stochastic number generator: encodes an unsigned value as a bitstream of
// 2^WIDTH - 1 bits whose count of ones equals the value, by comparing a
// full-period LFSR sequence against the loaded value.
`timescale 1ns/1ps
module sc_sng
    import sc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SEED  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             en,
    output logic             ready,
    output logic             out,
    output logic             valid,
    output logic             last
);

    // Counter value of the final stream bit (L-1 = 2^WIDTH - 2).
    localparam logic [WIDTH-1:0] LAST_CNT = {{(WIDTH-1){1'b1}}, 1'b0};

    sc_state_t        state_reg, state_next;
    logic [WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0] value_reg;
    logic [WIDTH-1:0] lfsr_state;
    logic             accept;
    logic             valid_int;
    logic             last_int;

    sc_lfsr #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (accept),
        .step  (valid_int),
        .state (lfsr_state)
    );

    // Stream handshake, output bit and next-state decode. A load accepted on
    // the last-bit cycle keeps the FSM in RUN so the next stream has no gap.
    always_comb begin
        state_next = state_reg;
        valid_int  = (state_reg == RUN) && en;
        last_int   = valid_int && (cnt_reg == LAST_CNT);
        ready      = (state_reg == IDLE) || last_int;
        accept     = load && ready;
        case (state_reg)
            IDLE: if (accept) state_next = RUN;
            RUN:  if (last_int) state_next = accept ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign valid = valid_int;
    assign last  = last_int;
    assign out   = valid_int && (lfsr_state <= value_reg);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Value capture and bit counter; both hold while the stream is paused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_reg <= '0;
            cnt_reg   <= '0;
        end else if (accept) begin
            value_reg <= value;
            cnt_reg   <= '0;
        end else if (valid_int) begin
            cnt_reg   <= cnt_reg + WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_sc_sng.sv
// Scoreboard bench for sc_sng (WIDTH=8, SEED=1): stimulus pushes the expected
// bit stream per accepted load, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_sc_sng;

    localparam int W = 8;
    localparam int L = 255;

    typedef struct {
        logic o;
        logic l;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         load;
    logic [W-1:0] value;
    logic         en;
    logic         ready;
    logic         out;
    logic         valid;
    logic         last;

    int   tests = 0;
    int   fails = 0;
    int   ones_mon = 0;
    bit   rand_en = 0;
    exp_t exp_q[$];
    int   ones_q[$];

    sc_sng #(.WIDTH(W), .SEED(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .value (value),
        .en    (en),
        .ready (ready),
        .out   (out),
        .valid (valid),
        .last  (last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("[TB] FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    // Independent reference: 8-bit LFSR taps {8,6,5,4}, seed 1.
    task automatic push_stream(input int v);
        logic [7:0] s;
        exp_t       e;
        s = 8'd1;
        for (int i = 0; i < L; i++) begin
            e.o = (int'(s) <= v);
            e.l = (i == L - 1);
            exp_q.push_back(e);
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        end
        ones_q.push_back(v);
        $display("[TB] load value=%0d queued %0d bits", v, L);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_en) en = 1'($urandom_range(0, 1));
    endtask

    task automatic start(input int v);
        check("ready_before_load", int'(ready), 1);
        load  = 1'b1;
        value = W'(v);
        push_stream(v);
        tick();
        load  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) check({name, "_timeout"}, exp_q.size(), 0);
        rand_en = 0;
        en      = 1'b1;
        #0;
        check({name, "_ready_after"}, int'(ready), 1);
        check({name, "_valid_after"}, int'(valid), 0);
    endtask

    task automatic wait_qsize(input int sz, input string name);
        int n;
        n = 0;
        while (exp_q.size() != sz && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) check({name, "_timeout"}, exp_q.size(), sz);
    endtask

    // Monitor: compare every presented bit against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            ones_mon = 0;
        end else if (valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("out_bit", int'(out), int'(e.o));
                check("last_flag", int'(last), int'(e.l));
                ones_mon += int'(out);
                if (e.l) begin
                    if (ones_q.size() == 0) begin
                        check("ones_queue_empty", 1, 0);
                    end else begin
                        check("stream_ones", ones_mon, ones_q.pop_front());
                        $display("[TB] stream done ones=%0d", ones_mon);
                    end
                    ones_mon = 0;
                end
            end
        end else begin
            check("idle_out_zero", int'(out), 0);
            check("idle_last_zero", int'(last), 0);
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        load  = 1'b0;
        value = '0;
        en    = 1'b1;
        #3;
        check("rst_ready", int'(ready), 1);
        check("rst_valid", int'(valid), 0);
        check("rst_out", int'(out), 0);
        check("rst_last", int'(last), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Value 0, 255, 128, 1 with en held high.
        start(0);   wait_done("v0");
        start(255); wait_done("v255");
        start(128); wait_done("v128");
        start(1);   wait_done("v1");

        // Random pausing must not change the sequence or count.
        rand_en = 1;
        start(100); wait_done("v100_rand_en");

        // Load accepted in IDLE with en low; nothing valid until en rises.
        en = 1'b0;
        start(60);
        repeat (3) begin
            check("paused_valid", int'(valid), 0);
            check("paused_ready", int'(ready), 0);
            tick();
        end
        en = 1'b1;
        wait_done("v60_paused_start");

        // Mid-stream load ignored, then back-to-back load on the last bit.
        start(50);
        repeat (10) tick();
        check("midstream_ready", int'(ready), 0);
        load  = 1'b1;
        value = 8'd77;
        tick();
        load  = 1'b0;
        wait_qsize(1, "to_last");
        check("last_before_b2b", int'(last), 1);
        check("ready_on_last", int'(ready), 1);
        load  = 1'b1;
        value = 8'd200;
        push_stream(200);
        tick();
        load  = 1'b0;
        check("b2b_no_bubble", int'(valid), 1);
        check("b2b_ready_low", int'(ready), 0);
        wait_done("v200_b2b");

        // Reset while bit 37 is on the output.
        start(100);
        wait_qsize(L - 37, "to_bit37");
        check("bit37_valid", int'(valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_ready", int'(ready), 1);
        check("abort_valid", int'(valid), 0);
        check("abort_out", int'(out), 0);
        check("abort_last", int'(last), 0);
        exp_q.delete();
        ones_q.delete();
        $display("[TB] reset asserted at bit 37");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("post_reset_valid", int'(valid), 0);
        start(100);
        wait_done("v100_after_reset");

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sc_sng.md
SC_SNG -- requirements
Module: sc_sng

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter WIDTH, default 8, SHALL set the binary value width; legal range 4..16.
REQ-003 Parameter SEED, default 1, SHALL set the LFSR start state; it must be nonzero and below 2^WIDTH.
REQ-004 Port clk, input, 1 bit: rising-edge clock.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port load, input, 1 bit: request to start a new stream; accepted on a rising edge when load=1 and ready=1.
REQ-007 Port value, input, WIDTH bits: unsigned magnitude to encode; sampled only on an accepted load.
REQ-008 Port en, input, 1 bit: stream advance enable; low pauses the stream.
REQ-009 Port ready, output, 1 bit: block can accept load.
REQ-010 Port out, output, 1 bit: stochastic bitstream, feeding the downstream mux adder's x or y input.
REQ-011 Port valid, output, 1 bit: out carries a stream bit this cycle.
REQ-012 Port last, output, 1 bit: final bit of the current stream.

Function
REQ-013 Stream length SHALL be L = 2^WIDTH - 1 valid bits per accepted load.
REQ-014 FSM states: IDLE and RUN.
- IDLE -> RUN on accepted load.
- RUN -> IDLE after the last bit is consumed, unless a load is accepted that same cycle; then it stays in RUN.
REQ-015 ready SHALL be 1 in IDLE, and in RUN only during the cycle where last=1 and en=1; otherwise 0.
REQ-016 On an accepted load:
- value_q <= value;
- LFSR <= SEED;
- bit counter <= 0.
REQ-017 The first valid bit SHALL appear in the cycle immediately after the load edge.
REQ-018 In RUN, valid SHALL equal en.
REQ-019 out SHALL be (lfsr <= value_q) while valid=1, and 0 whenever valid=0.
REQ-020 On each edge with valid=1, the LFSR SHALL advance one step and the counter SHALL increment; with en=0, the LFSR, counter and value_q SHALL hold.
REQ-021 last SHALL be 1 when valid=1 and counter = L-1; otherwise 0.
REQ-022 The LFSR SHALL be Fibonacci, shifting toward the MSB, with new LSB = XOR of the tap bits and a maximal period of L states over 1..L.
- Tap table: 4:{4,3}; 5:{5,3}; 6:{6,5}; 7:{7,6}; 8:{8,6,5,4}; 9:{9,5}; 10:{10,7}; 11:{11,9}; 12:{12,11,10,4}; 13:{13,12,11,8}; 14:{14,13,12,2}; 15:{15,14}; 16:{16,15,13,4}.
REQ-023 Over one complete stream, the number of ones on out SHALL equal value_q exactly (0..L); the encoded probability is value_q/L.
REQ-024 load while ready=0 SHALL be ignored, with no state change.
REQ-025 Back-to-back streams: a load accepted on the last-bit edge SHALL make the next cycle bit 0 of the new stream, with no bubble.
REQ-026 A load held high in IDLE when en=0 SHALL still be accepted; valid stays 0 until en=1.

Reset
REQ-027 While rst_n=0, the block SHALL asynchronously force:
- state = IDLE, lfsr = SEED, counter = 0, value_q = 0;
- outputs ready=1, valid=0, out=0, last=0.
REQ-028 Reset asserted mid-stream SHALL abort the stream immediately; no partial-stream bits SHALL appear after rst_n rises.

Structure
REQ-029 Shared package sc_pkg SHALL hold the FSM state encoding (IDLE=0, RUN=1) and the WIDTH-indexed LFSR tap-mask function/constants, for reuse by other SC generators.
REQ-030 A sub-module sc_lfsr (params WIDTH and SEED; ports clk, rst_n, init, step, state) SHALL implement the LFSR; sc_sng SHALL hold the FSM, counter, value register and comparator.

Verification
REQ-031 WIDTH=8, load value=0, en=1 -> 255 valid cycles, zero ones, last high on the 255th valid cycle only, ready=1 after.
REQ-032 WIDTH=8, value=255 -> 255 ones; value=128 -> exactly 128 ones; value=1 -> exactly 1 one.
REQ-033 WIDTH=8, value=100, en toggled 0/1 pseudo-randomly -> still 255 valid bits, 100 ones, and the bit sequence identical to the en=1 run.
REQ-034 load value=50, then load=1 during the last cycle with value=200 -> no gap cycle; second stream has 200 ones; loads pulsed mid-stream are ignored.
REQ-035 Reset at bit 37 of a stream -> out/valid/last go 0 and ready goes 1 before the next edge; a fresh load afterwards reproduces the SEED sequence from bit 0.
